mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; all cycle counts below are stated for WIDTH=32 and scale as WIDTH+1.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port ctrl_reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-004 SHALL have port data_operandA  input  WIDTH  dividend/multiplicand, two's complement, driven from register-file read port A.
REQ-005 SHALL have port data_operandB  input  WIDTH  divisor/multiplier, two's complement, driven from register-file read port B.
REQ-006 SHALL have port ctrl_MULT  input  1  one-cycle start pulse for signed multiply.
REQ-007 SHALL have port ctrl_DIV  input  1  one-cycle start pulse for signed divide.
REQ-008 SHALL have port data_result  output  WIDTH  product low word or quotient; feeds register-file data_writeReg.
REQ-009 SHALL have port data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle pulse marking data_result/data_exception valid.

Function
REQ-011 SHALL latch data_operandA and data_operandB at the rising edge that samples ctrl_MULT=1 or ctrl_DIV=1; later operand changes SHALL have no effect.
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE: IDLE->MUL on ctrl_MULT, IDLE->DIV on ctrl_DIV, MUL/DIV->DONE after WIDTH iteration edges, DONE->IDLE next edge.
REQ-013 SHALL perform one shift-add (MUL) or one restoring-subtract (DIV) iteration per clock on operand magnitudes, applying sign correction at DONE.
REQ-014 SHALL assert data_resultRDY for exactly one cycle, starting 33 rising edges after the edge that sampled the start pulse.
REQ-015 SHALL, for MULT, output the low WIDTH bits of the 2*WIDTH-bit signed product.
REQ-016 SHALL, for MULT, set data_exception=1 when the full product differs from the sign extension of its low WIDTH bits.
REQ-017 SHALL, for DIV, output the signed quotient truncated toward zero; the remainder is discarded.
REQ-018 SHALL, for DIV with data_operandB=0, output data_result=0 and data_exception=1 at normal latency.
REQ-019 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, output data_result=0x80000000 and data_exception=1.
REQ-020 SHALL hold data_result and data_exception stable from the RDY cycle until the next RDY pulse or reset.
REQ-021 SHALL, when a start pulse arrives in MUL, DIV or DONE, abort the current operation without a RDY pulse and restart with newly latched operands.
REQ-022 SHALL, when ctrl_MULT and ctrl_DIV are both 1 in one cycle, perform MULT only.
REQ-023 SHALL ignore start pulses sampled during the same edge that applies reset.

Reset
REQ-024 SHALL, on reset, enter IDLE and drive data_result=0, data_exception=0, data_resultRDY=0 from the next cycle, from any state including mid-operation.
REQ-025 SHALL clear all internal iteration counters and partial results on reset so no stale RDY pulse occurs afterward.

Verification
REQ-026 SHALL verify MULT 7 x 0xFFFFFFFD -> data_result=0xFFFFFFEB, exception 0, RDY exactly 33 edges after start.
REQ-027 SHALL verify MULT 0x00010000 x 0x00010000 -> data_result=0x00000000, exception 1.
REQ-028 SHALL verify DIV 0xFFFFFFF9 / 2 -> data_result=0xFFFFFFFD, exception 0; and DIV 5 / 0 -> data_result=0, exception 1.
REQ-029 SHALL verify DIV 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, exception 1.
REQ-030 SHALL verify MULT 3x4 started, DIV 100/7 pulsed 10 edges later -> single RDY 33 edges after DIV pulse, data_result=14.
REQ-031 SHALL verify ctrl_reset=0 at edge 5 of a MULT -> no RDY pulse ever for that operation, all outputs 0, next MULT 2x2 returns 4.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide unit: one shift-add or restoring-subtract
// step per clock on operand magnitudes, with sign correction in the DONE state.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned DW = 2 * WIDTH;
   localparam int unsigned PW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t           state;
   logic             is_mul;
   logic             neg;
   logic             div_zero;
   logic [WIDTH-1:0] opnd;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic [PW-1:0]    acc_next;
   logic [DW-1:0]    prod_s;
   logic [WIDTH-1:0] quo_s;
   logic [WIDTH-1:0] res_c;
   logic             exc_c;

   // acc holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      mag_a    = data_operandA[WIDTH-1] ? WIDTH'(0) - data_operandA : data_operandA;
      mag_b    = data_operandB[WIDTH-1] ? WIDTH'(0) - data_operandB : data_operandB;
      add_sum  = acc[PW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
      shifted  = acc[DW-1:WIDTH-1];
      diff     = {1'b0, shifted} - {2'b00, opnd};
      acc_next = acc;
      if (is_mul) begin
         acc_next = {1'b0, add_sum, acc[WIDTH-1:1]};
      end else if (diff[WIDTH+1]) begin
         acc_next = {shifted, acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction and exception detection applied to the finished magnitude
   always_comb begin
      prod_s = neg ? DW'(0) - acc[DW-1:0] : acc[DW-1:0];
      quo_s  = neg ? WIDTH'(0) - acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_c  = '0;
      exc_c  = 1'b0;
      if (is_mul) begin
         res_c = prod_s[WIDTH-1:0];
         exc_c = prod_s[DW-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
      end else if (div_zero) begin
         res_c = '0;
         exc_c = 1'b1;
      end else begin
         res_c = quo_s;
         exc_c = !neg && acc[WIDTH-1];
      end
   end

   // Control FSM; a start pulse in any state aborts and restarts
   always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
         state          <= IDLE;
         is_mul         <= 1'b0;
         neg            <= 1'b0;
         div_zero       <= 1'b0;
         opnd           <= '0;
         acc            <= '0;
         cnt            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_MULT || ctrl_DIV) begin
            is_mul   <= ctrl_MULT;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= !ctrl_MULT && (data_operandB == '0);
            opnd     <= ctrl_MULT ? mag_a : mag_b;
            acc      <= PW'(ctrl_MULT ? mag_b : mag_a);
            cnt      <= '0;
            state    <= ctrl_MULT ? MUL : DIV;
         end else begin
            case (state)
               MUL, DIV: begin
                  acc <= acc_next;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) begin
                     state <= DONE;
                  end
               end
               DONE: begin
                  data_result    <= res_c;
                  data_exception <= exc_c;
                  data_resultRDY <= 1'b1;
                  state          <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, multi-cycle corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

   localparam int unsigned W = 32;

   logic         clock = 1'b0;
   logic         ctrl_reset = 1'b0;
   logic [W-1:0] data_operandA = '0;
   logic [W-1:0] data_operandB = '0;
   logic         ctrl_MULT = 1'b0;
   logic         ctrl_DIV = 1'b0;
   logic [W-1:0] data_result;
   logic         data_exception;
   logic         data_resultRDY;

   int n_tests = 0;
   int n_fail = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock          (clock),
      .ctrl_reset     (ctrl_reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          mul;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        e;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Signed arithmetic reference: product/quotient in 64-bit integers
   function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint sa, sb, p, q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (mul) begin
         p = sa * sb;
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (sb == 0) begin
         r = '0;
         e = 1'b1;
      end else begin
         q = sa / sb;
         r = q[31:0];
         e = (q > 64'sd2147483647) || (q < -64'sd2147483648);
      end
   endfunction

   task automatic pulse(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = mul;
      ctrl_DIV = div;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Watch a bounded number of edges; report first RDY edge, RDY-high count and sampled result
   task automatic mon(input int edges, output int first, output int count,
                      output logic [31:0] res, output logic exc);
      first = -1;
      count = 0;
      res = '0;
      exc = 1'b0;
      for (int i = 1; i <= edges; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) begin
            count++;
            if (first < 0) begin
               first = i;
               res = data_result;
               exc = data_exception;
            end
         end
      end
   endtask

   task automatic run_op(input string name, input bit mul, input bit div, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee);
      int first, count;
      logic [31:0] res;
      logic exc;
      pulse(mul, div, a, b);
      mon(40, first, count, res, exc);
      chk({name, " latency"}, 64'(first), 64'd33);
      chk({name, " rdy_cycles"}, 64'(count), 64'd1);
      chk({name, " result"}, 64'(res), 64'(er));
      chk({name, " exception"}, 64'(exc), 64'(ee));
      chk({name, " hold"}, 64'(data_result), 64'(er));
   endtask

   initial begin
      int first, count;
      logic [31:0] res, mr;
      logic exc, me;
      bit mul;
      logic [31:0] a, b;

      vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[2]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[4]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
      vecs[6]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[8]  = '{1'b0, 32'd100,       32'd7,         32'd14,        1'b0};
      vecs[9]  = '{1'b0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0};
      vecs[10] = '{1'b0, 32'd7,         32'hFFFF_FF9C, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
      vecs[12] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b1, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b1};
      vecs[14] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
      vecs[15] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("reset result", 64'(data_result), 64'd0);
      chk("reset exception", 64'(data_exception), 64'd0);
      chk("reset rdy", 64'(data_resultRDY), 64'd0);
      @(negedge clock);
      ctrl_reset = 1'b1;

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].mul, !vecs[i].mul, vecs[i].a, vecs[i].b,
                vecs[i].r, vecs[i].e);
      end

      // Simultaneous pulses perform MULT
      run_op("both_pulses", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

      // DIV pulse 10 edges into a MULT restarts it
      pulse(1'b1, 1'b0, 32'd3, 32'd4);
      mon(9, first, count, res, exc);
      chk("abort_mul early_rdy", 64'(count), 64'd0);
      pulse(1'b0, 1'b1, 32'd100, 32'd7);
      mon(40, first, count, res, exc);
      chk("abort_mul latency", 64'(first), 64'd33);
      chk("abort_mul rdy_cycles", 64'(count), 64'd1);
      chk("abort_mul result", 64'(res), 64'd14);
      chk("abort_mul exception", 64'(exc), 64'd0);

      // Start pulse while in DONE suppresses that RDY
      pulse(1'b1, 1'b0, 32'd5, 32'd5);
      mon(32, first, count, res, exc);
      chk("abort_done early_rdy", 64'(count), 64'd0);
      pulse(1'b0, 1'b1, 32'd9, 32'd3);
      mon(40, first, count, res, exc);
      chk("abort_done latency", 64'(first), 64'd33);
      chk("abort_done rdy_cycles", 64'(count), 64'd1);
      chk("abort_done result", 64'(res), 64'd3);

      // Reset at edge 5 of a MULT
      pulse(1'b1, 1'b0, 32'd3, 32'd3);
      mon(4, first, count, res, exc);
      @(negedge clock);
      ctrl_reset = 1'b0;
      @(posedge clock);
      #1;
      ctrl_reset = 1'b1;
      chk("midreset result", 64'(data_result), 64'd0);
      chk("midreset exception", 64'(data_exception), 64'd0);
      chk("midreset rdy", 64'(data_resultRDY), 64'd0);
      mon(50, first, count, res, exc);
      chk("midreset stale_rdy", 64'(count), 64'd0);
      chk("midreset result_after", 64'(data_result), 64'd0);
      run_op("after_reset", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);

      // Start pulse coincident with reset is ignored
      @(negedge clock);
      ctrl_reset = 1'b0;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd9;
      data_operandB = 32'd9;
      @(posedge clock);
      #1;
      ctrl_reset = 1'b1;
      ctrl_MULT = 1'b0;
      mon(40, first, count, res, exc);
      chk("reset_start rdy", 64'(count), 64'd0);
      chk("reset_start result", 64'(data_result), 64'd0);

      // Randomized operations against the reference model
      for (int n = 0; n < 60; n++) begin
         mul = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 32'($urandom_range(0, 15)) - 32'd8;
            2: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
         model(mul, a, b, mr, me);
         run_op($sformatf("rand%0d %s 0x%0h 0x%0h", n, mul ? "mul" : "div", a, b),
                mul, !mul, a, b, mr, me);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
